cpu_state_dump: RTL and testbench
=================================

# cpu_state_dump

Hardware end-of-program state dumper that sits directly downstream of the `cpu` core. It watches the committed/fetched instruction stream for the halt encodings. After a halt it waits a fixed pipeline-drain interval, then walks the register file and data memory through dedicated read ports. It emits one record per register and one per non-zero memory word on a valid/ready stream, giving the same content as the simulation dump, in hardware.

## Interface
- `DRAIN_CYCLES`, 10: cycles waited after halt before the first read; range 0–255.
- `MEM_AW`, 16: data-memory address width; the scan covers 0 … 2^MEM_AW−1.
- `NUM_REGS`, 16: registers dumped, index 0 … NUM_REGS−1.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instr` in 16: instruction word from the CPU.
- `instr_valid` in 1: `instr` is meaningful this cycle.
- `reg_re` out 1: register read strobe.
- `reg_addr` out 4: register index.
- `reg_rdata` in 16: register data, valid 1 cycle after `reg_re`.
- `mem_re` out 1: data-memory read strobe.
- `mem_addr` out MEM_AW: memory address.
- `mem_rdata` in 16: memory data, valid 1 cycle after `mem_re`.
- `out_valid` out 1: record available.
- `out_ready` in 1: consumer accepts the record.
- `out_kind` out 1: 0 = register, 1 = memory.
- `out_addr` out 16: register index or memory address, zero-extended.
- `out_data` out 16: value.
- `busy` out 1: high from halt detection until DONE.
- `done` out 1: sticky high after the last record is accepted.

## Operation
- Halt condition: `instr_valid` is high and `instr` is 0xE000 or 0xE7FF.
- FSM states:
  - IDLE: on halt, go to DRAIN and load the drain counter with DRAIN_CYCLES. If DRAIN_CYCLES = 0, go straight to REG_RD.
  - DRAIN: decrement each cycle; at 0, go to REG_RD.
  - REG_RD: drive `reg_re`=1 with `reg_addr`=idx; go to REG_CAP.
  - REG_CAP: latch `reg_rdata` into the output holding register; go to OUT.
  - MEM_RD: drive `mem_re`=1 with `mem_addr`=addr; go to MEM_CAP.
  - MEM_CAP:
    - If `mem_rdata` is 0: skip. Advance addr and go to MEM_RD, or go to DONE if addr is the last address.
    - Otherwise: latch into the holding register and go to OUT.
  - OUT: hold `out_valid`=1 with stable `out_kind`/`out_addr`/`out_data` until `out_ready`. On acceptance, advance:
    - register idx < NUM_REGS−1: next register, go to REG_RD;
    - last register: set addr=0, go to MEM_RD;
    - memory addr < last: addr+1, go to MEM_RD;
    - last memory address: go to DONE.
  - DONE: `done`=1 and `busy`=0, held until reset. Halts seen in DONE are ignored.
- Registers are always emitted, including zero values. Memory words equal to 0 are never emitted.
- Halts seen while `busy` is high are ignored. `instr` is don't-care when `instr_valid`=0.
- The memory address counter must not wrap. Use MEM_AW+1 bits or an explicit last-address flag, so the scan terminates exactly after address 2^MEM_AW−1.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- Reset deassertion is synchronised internally. `reset_n` low mid-dump aborts immediately to IDLE with all outputs 0 and no partial record retained.
- Halt sampled at edge t (DRAIN_CYCLES = D):
  - the first `reg_re` is high in cycle t+D+1;
  - the first `out_valid` is high in cycle t+D+3.
- Per record: 3 cycles minimum (RD, CAP, OUT) with `out_ready` held high.
- A skipped zero memory word costs 2 cycles.
- `out_valid` never drops without acceptance. Record fields are stable while `out_valid & !out_ready`.
- `reg_re`/`mem_re` are single-cycle pulses. They are never asserted together, and never asserted while in OUT.
- `done` rises in the cycle after the final handshake, or after the final skipped read.

## Structure
- Package `cpu_dump_pkg`:
  - `dump_state_t` enum;
  - `HALT_OP_A`=16'hE000 and `HALT_OP_B`=16'hE7FF;
  - `KIND_REG`/`KIND_MEM`;
  - record struct {kind, addr, data}.
- Sub-module `cpu_halt_detect`: the registered halt pulse plus the `busy` gating. Everything else is one FSM module.

## Test plan
- Test configuration: MEM_AW=4, D=10, `out_ready` tied high.
- Nominal dump:
  - Stimulus: registers r0–r15 = 100+i; mem[3]=7; mem[15]=0xFFFF; all other memory 0; halt 0xE000.
  - Required response: exactly 18 records. The 16 register records come first in index order, then (1,3,7), then (1,15,0xFFFF). `done` is high after the last record.
- Latency:
  - Stimulus: halt 0xE7FF at edge t.
  - Required response: `reg_re` high at t+11 with `reg_addr`=0; first `out_valid` at t+13 with data 100.
- Backpressure:
  - Stimulus: `out_ready` random at 30% high.
  - Required response: identical record sequence. Fields stay stable while stalled, and no record is duplicated or dropped.
- False halt and invalid instruction:
  - Stimulus: instr 0xE001, or 0xE000 with `instr_valid`=0, over 50 cycles.
  - Required response: `busy` stays 0 and no reads are issued.
- Reset mid-dump and ignored halts:
  - Stimulus: assert `reset_n`=0 during the memory scan, then rerun; also send a second halt while `busy` is high.
  - Required response: on reset, all outputs go to 0 asynchronously, and the rerun produces the full 18 records. The second halt has no effect.
- Zero drain and all-zero memory:
  - Stimulus: D=0 and all memory 0.
  - Required response: 16 register records only; `reg_re` at t+1; `done` asserted after the 16 address-skip reads.

Source files
------------

// File: rtl/cpu_dump_pkg.sv
// cpu_dump_pkg: shared types and constants for the end-of-program state dumper.
package cpu_dump_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_DRAIN, ST_REG_RD, ST_REG_CAP, ST_MEM_RD, ST_MEM_CAP, ST_OUT, ST_DONE
    } dump_state_t;
    localparam logic [15:0] HALT_OP_A = 16'hE000;
    localparam logic [15:0] HALT_OP_B = 16'hE7FF;
    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;
    typedef struct packed {
        logic        kind;
        logic [15:0] addr;
        logic [15:0] data;
    } dump_rec_t;
    function automatic logic is_halt(input logic [15:0] op);
        return op == HALT_OP_A || op == HALT_OP_B;
    endfunction
endpackage

// File: rtl/cpu_halt_detect.sv
// cpu_halt_detect: registered single-cycle halt pulse, suppressed while a dump is running or finished.
module cpu_halt_detect
    import cpu_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        active_i,
    input  logic        done_i,
    output logic        halt_o,
    output logic        busy_o
);
    logic halt_q, halt_d;
    assign busy_o = halt_q | active_i;
    assign halt_d = instr_valid_i & is_halt(instr_i) & ~busy_o & ~done_i;
    assign halt_o = halt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt_q <= 1'b0;
        else        halt_q <= halt_d;
    end
endmodule

// File: rtl/cpu_state_dump.sv
// cpu_state_dump: after a CPU halt and a drain delay, streams every register and
// every non-zero data-memory word out as {kind, addr, data} records.
module cpu_state_dump
    import cpu_dump_pkg::*;
#(
    parameter int DRAIN_CYCLES = 10,
    parameter int MEM_AW       = 16,
    parameter int NUM_REGS     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              reg_re,
    output logic [3:0]        reg_addr,
    input  logic [15:0]       reg_rdata,
    output logic              mem_re,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_kind,
    output logic [15:0]       out_addr,
    output logic [15:0]       out_data,
    output logic              busy,
    output logic              done
);
    localparam logic [MEM_AW-1:0] ADDR_ONE = MEM_AW'(1);
    logic [1:0]        rst_sync_q;
    logic              rst_n;
    dump_state_t       state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    dump_rec_t         rec_q, rec_d;
    logic              halt, active, last_addr, last_reg;

    // Assert asynchronously, release two edges later so no flop sees a runt reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign active    = state_q != ST_IDLE && state_q != ST_DONE;
    assign done      = state_q == ST_DONE;
    assign last_addr = &addr_q;
    assign last_reg  = idx_q == 4'(NUM_REGS - 1);

    cpu_halt_detect u_halt (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_i      (instr),
        .instr_valid_i(instr_valid),
        .active_i     (active),
        .done_i       (done),
        .halt_o       (halt),
        .busy_o       (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            rec_q   <= rec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        rec_d   = rec_q;
        case (state_q)
            ST_IDLE: if (halt) begin
                state_d = DRAIN_CYCLES == 0 ? ST_REG_RD : ST_DRAIN;
                cnt_d   = 8'(DRAIN_CYCLES - 1);
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd0) state_d = ST_REG_RD;
            end
            ST_REG_RD: state_d = ST_REG_CAP;
            ST_REG_CAP: begin
                rec_d   = '{kind: KIND_REG, addr: 16'(idx_q), data: reg_rdata};
                state_d = ST_OUT;
            end
            ST_MEM_RD: state_d = ST_MEM_CAP;
            ST_MEM_CAP: if (mem_rdata != 16'd0) begin
                rec_d   = '{kind: KIND_MEM, addr: 16'(addr_q), data: mem_rdata};
                state_d = ST_OUT;
            end else begin
                addr_d  = addr_q + ADDR_ONE;
                state_d = last_addr ? ST_DONE : ST_MEM_RD;
            end
            ST_OUT: if (out_ready) begin
                if (rec_q.kind == KIND_REG) begin
                    idx_d   = idx_q + 4'd1;
                    addr_d  = '0;
                    state_d = last_reg ? ST_MEM_RD : ST_REG_RD;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = last_addr ? ST_DONE : ST_MEM_RD;
                end
            end
            default: ;
        endcase
    end

    assign reg_re    = state_q == ST_REG_RD;
    assign reg_addr  = idx_q;
    assign mem_re    = state_q == ST_MEM_RD;
    assign mem_addr  = addr_q;
    assign out_valid = state_q == ST_OUT;
    assign out_kind  = rec_q.kind;
    assign out_addr  = rec_q.addr;
    assign out_data  = rec_q.data;
endmodule

// File: tb/tb_cpu_state_dump.sv
// tb_cpu_state_dump: two dumpers (drain 10 and drain 0, MEM_AW=4) against a record-list reference.
module tb_cpu_state_dump;
    import cpu_dump_pkg::*;
    typedef struct { logic [15:0] op; logic vld; logic hit; } hvec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic out_ready = 1'b1;
    logic [15:0] instr = '0;
    logic iv [2];
    logic reg_re [2], mem_re [2], out_valid [2], out_kind [2], busy [2], done [2];
    logic [3:0] reg_addr [2], mem_addr [2];
    logic [15:0] reg_rdata [2], mem_rdata [2], out_addr [2], out_data [2];
    logic [15:0] regs [16], mem [16];
    dump_rec_t got [$], exp_q [$];
    int errors = 0, checks = 0, viol = 0, sel = 0;
    bit rdy_rand = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_state_dump #(.DRAIN_CYCLES(g == 0 ? 10 : 0), .MEM_AW(4), .NUM_REGS(16)) u_dut (
            .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(iv[g]),
            .reg_re(reg_re[g]), .reg_addr(reg_addr[g]), .reg_rdata(reg_rdata[g]),
            .mem_re(mem_re[g]), .mem_addr(mem_addr[g]), .mem_rdata(mem_rdata[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready), .out_kind(out_kind[g]),
            .out_addr(out_addr[g]), .out_data(out_data[g]), .busy(busy[g]), .done(done[g])
        );
    end

    // register file and data memory with one-cycle read latency
    always @(posedge clk)
        for (int k = 0; k < 2; k++) begin
            if (reg_re[k]) reg_rdata[k] <= regs[reg_addr[k]];
            if (mem_re[k]) mem_rdata[k] <= mem[mem_addr[k]];
        end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial forever begin
        @(posedge clk); #1;
        out_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    // handshake capture, stall stability and strobe rules on the selected instance
    initial begin
        dump_rec_t cur, held;
        bit stalled = 1'b0, prev_re = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 1'b0;
                prev_re = 1'b0;
            end else begin
                cur = {out_kind[sel], out_addr[sel], out_data[sel]};
                if (stalled && out_valid[sel]) check("stall_stable", cur, held);
                if (stalled && !out_valid[sel]) viol++;
                if (reg_re[sel] && mem_re[sel]) viol++;
                if ((reg_re[sel] || mem_re[sel]) && out_valid[sel]) viol++;
                if (prev_re && (reg_re[sel] || mem_re[sel])) viol++;
                prev_re = reg_re[sel] | mem_re[sel];
                if (out_valid[sel] && out_ready) got.push_back(cur);
                stalled = out_valid[sel] && !out_ready;
                held = cur;
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic fill(input bit rnd, input bit mem_on);
        for (int i = 0; i < 16; i++) begin
            regs[i] = rnd ? 16'($urandom) : 16'(100 + i);
            mem[i] = (rnd && mem_on && $urandom_range(0, 9) < 3) ? 16'($urandom_range(1, 65535)) : 16'd0;
        end
        if (!rnd && mem_on) begin
            mem[3] = 16'd7;
            mem[15] = 16'hFFFF;
        end
    endtask

    task automatic halt(input int s, input logic [15:0] op);
        instr = op;
        iv[s] = 1'b1;
        tick();
        iv[s] = 1'b0;
        instr = 16'($urandom);
    endtask

    task automatic run_dump(input int s, input logic [15:0] op, input string name);
        int d = (s == 0) ? 10 : 0;
        int n = 0;
        int cyc = d + 1 + 3 * 16;
        exp_q = {};
        for (int i = 0; i < 16; i++) exp_q.push_back('{KIND_REG, 16'(i), regs[i]});
        for (int a = 0; a < 16; a++) begin
            cyc += (mem[a] != 16'd0) ? 3 : 2;
            if (mem[a] != 16'd0) exp_q.push_back('{KIND_MEM, 16'(a), mem[a]});
        end
        got = {};
        sel = s;
        viol = 0;
        halt(s, op);
        while (!reg_re[s] && n < 100) begin tick(); n++; end
        check({name, "_first_re"}, 64'(n), 64'(d + 1));
        while (!done[s] && n < 5000) begin tick(); n++; end
        if (!rdy_rand) check({name, "_done_cycle"}, 64'(n), 64'(cyc));
        check({name, "_done_busy"}, {done[s], busy[s]}, 2'b10);
        check({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_rec%0d", name, i), got[i], exp_q[i]);
        check({name, "_protocol"}, 64'(viol), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        hvec_t tbl [9];
        int n;
        logic bad;
        tbl = '{'{16'hE000, 1'b1, 1'b1}, '{16'hE7FF, 1'b1, 1'b1}, '{16'hE001, 1'b1, 1'b0},
                '{16'hE000, 1'b0, 1'b0}, '{16'hE7FF, 1'b0, 1'b0}, '{16'h0000, 1'b1, 1'b0},
                '{16'h6000, 1'b1, 1'b0}, '{16'hE7FE, 1'b1, 1'b0}, '{16'hF7FF, 1'b1, 1'b0}};
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        fill(1'b0, 1'b1);
        tick();
        reset_n = 1'b0;
        tick(2);
        check("reset_outputs", {reg_re[0], mem_re[0], out_valid[0], out_kind[0], busy[0], done[0],
                                reg_addr[0], mem_addr[0], out_addr[0], out_data[0]}, 64'd0);
        reset_n = 1'b1;
        tick(3);

        foreach (tbl[v]) begin
            do_reset();
            instr = tbl[v].op;
            iv[0] = tbl[v].vld;
            tick();
            iv[0] = 1'b0;
            instr = 16'($urandom);
            check($sformatf("tbl%0d_busy", v), busy[0], tbl[v].hit);
            tick(11);
            check($sformatf("tbl%0d_reg_re", v), reg_re[0], tbl[v].hit);
        end

        do_reset();
        fill(1'b0, 1'b1);
        run_dump(0, HALT_OP_A, "nominal");
        halt(0, HALT_OP_A);
        tick(15);
        check("halt_in_done", {busy[0], done[0], reg_re[0]}, 3'b010);

        do_reset();
        halt(0, HALT_OP_B);
        tick(10);
        check("lat_t10", reg_re[0], 1'b0);
        tick();
        check("lat_t11", {reg_re[0], reg_addr[0]}, {1'b1, 4'd0});
        tick();
        check("lat_t12", out_valid[0], 1'b0);
        tick();
        check("lat_t13", {out_valid[0], out_kind[0], out_data[0]}, {1'b1, KIND_REG, 16'd100});

        rdy_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            fill(r > 0, 1'b1);
            do_reset();
            run_dump(0, r % 2 ? HALT_OP_B : HALT_OP_A, $sformatf("bp%0d", r));
        end
        rdy_rand = 1'b0;
        tick();

        do_reset();
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            iv[0] = (i % 2) == 0;
            instr = (i % 2) ? HALT_OP_A : 16'hE001 ^ 16'($urandom_range(0, 255) << 8);
            tick();
            bad |= busy[0] | reg_re[0] | mem_re[0];
        end
        iv[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            bad |= busy[0] | reg_re[0] | mem_re[0];
        end
        check("false_halt", bad, 1'b0);

        do_reset();
        fill(1'b0, 1'b1);
        sel = 0;
        got = {};
        halt(0, HALT_OP_A);
        tick(5);
        halt(0, HALT_OP_B);
        n = 0;
        while (!mem_re[0] && n < 500) begin tick(); n++; end
        check("mid_reached", mem_re[0], 1'b1);
        tick(3);
        reset_n = 1'b0;
        #1;
        check("mid_reset_outputs", {reg_re[0], mem_re[0], out_valid[0], out_kind[0], busy[0], done[0],
                                    reg_addr[0], mem_addr[0], out_addr[0], out_data[0]}, 64'd0);
        check("mid_reg_count", 64'(got.size()), 64'd16);
        for (int i = 0; i < got.size() && i < 16; i++)
            check($sformatf("mid_rec%0d", i), got[i], {KIND_REG, 16'(i), regs[i]});
        tick(2);
        reset_n = 1'b1;
        tick(3);
        run_dump(0, HALT_OP_A, "rerun");

        do_reset();
        fill(1'b1, 1'b0);
        run_dump(1, HALT_OP_A, "zero_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
